// File: rtl/hamming_byte_assembler.sv
// Hamming(7,4) correcting nibble-to-byte assembler for the UART receive path.
// Pairs corrected nibbles (low first) into bytes and buffers them in a small FIFO.
module hamming_byte_assembler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [6:0]               data_in,
  input  logic                     valid_in,
  output logic [7:0]               out_data,
  output logic                     out_corrected,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               err_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(DEPTH);
  localparam logic [15:0]     TmoLast  = 16'(TIMEOUT - 1);

  logic [6:0]      code_q;
  logic            code_v_q, code_v_d;
  logic            half_q, half_d;
  logic [3:0]      lo_q, lo_d;
  logic            lo_err_q, lo_err_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [7:0]      err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [8:0]      mem [DEPTH];

  logic [2:0] syn;
  logic [6:0] fixed;
  logic [3:0] nibble;
  logic       nib_err;
  logic       push_req, push, pop;
  logic [8:0] head;

  // Syndrome value equals the 1-based position of the flipped bit.
  always_comb begin
    syn[0] = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
    syn[1] = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
    syn[2] = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
    for (int i = 0; i < 7; i++) begin
      fixed[i] = code_q[i] ^ (syn == 3'(i + 1));
    end
    nibble  = {fixed[6], fixed[5], fixed[4], fixed[2]};
    nib_err = |syn;
  end

  always_comb begin
    code_v_d = code_v_q;
    half_d   = half_q;
    lo_d     = lo_q;
    lo_err_d = lo_err_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    if (ena) begin
      code_v_d = valid_in;
      if (code_v_q) begin
        tmo_d = '0;
        if (nib_err && err_q != 8'hFF) err_d = err_q + 8'd1;
        if (!half_q) begin
          half_d   = 1'b1;
          lo_d     = nibble;
          lo_err_d = nib_err;
        end else begin
          half_d = 1'b0;
        end
      end else if (half_q) begin
        if (tmo_q == TmoLast) begin
          half_d = 1'b0;
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end else begin
        tmo_d = '0;
      end
    end
  end

  assign push_req = ena & code_v_q & half_q;
  assign pop      = ena & out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & ((level_q != DepthLvl) | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      level_d = level_q + LvlW'(1);
    else if (pop && !push) level_d = level_q - LvlW'(1);
    if (push_req && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= '0;
      code_v_q <= 1'b0;
      half_q   <= 1'b0;
      lo_q     <= '0;
      lo_err_q <= 1'b0;
      tmo_q    <= '0;
      err_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (ena && valid_in) code_q <= data_in;
      code_v_q <= code_v_d;
      half_q   <= half_d;
      lo_q     <= lo_d;
      lo_err_q <= lo_err_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {nib_err | lo_err_q, nibble, lo_q};
  end

  assign head          = mem[rd_ptr_q];
  assign out_valid     = (level_q != '0);
  assign out_data      = out_valid ? head[7:0] : 8'h00;
  assign out_corrected = out_valid & head[8];
  assign err_count     = err_q;
  assign overflow      = ovf_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_hamming_byte_assembler.sv
// Directed bench for hamming_byte_assembler: decode table, FIFO full/overflow,
// pairing timeout boundaries, enable hold, error saturation and async reset.
module tb_hamming_byte_assembler;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [6:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic [7:0] out_data;
  logic       out_corrected;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] err_count;
  logic       overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;

  hamming_byte_assembler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .out_data      (out_data),
    .out_corrected (out_corrected),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_count     (err_count),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] lo_code;
    logic [6:0] hi_code;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_corr;
    int         exp_errs;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the codeword is sampled at the next posedge.
  task automatic pulse(input logic [6:0] code);
    data_in  = code;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] d, input logic c);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(d));
    chk({name, "_corr"}, 32'(out_corrected), 32'(c));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_data"}, 32'(out_data), 32'h0);
    chk({name, "_corr"}, 32'(out_corrected), 32'h0);
    chk({name, "_valid"}, 32'(out_valid), 32'h0);
    chk({name, "_err"}, 32'(err_count), 32'h0);
    chk({name, "_ovf"}, 32'(overflow), 32'h0);
    chk({name, "_level"}, 32'(fifo_level), 32'h0);
  endtask

  initial begin
    logic [6:0] m;
    vecs[0] = '{7'h2D, 7'h52, 72, 8'hA5, 1'b0, 0};
    vecs[1] = '{7'h00, 7'h7F, 1, 8'hF0, 1'b0, 0};
    vecs[2] = '{7'h7F, 7'h00, 1, 8'h0F, 1'b0, 0};
    for (int i = 0; i < 7; i++) begin
      m = 7'(1) << i;
      vecs[3 + i]  = '{7'h2D ^ m, 7'h52, 1, 8'hA5, 1'b1, 1};
      vecs[10 + i] = '{7'h2D, 7'h52 ^ m, 1, 8'hA5, 1'b1, 1};
    end

    #1 check_reset_outputs("reset");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Decode table; gap of 1 means back-to-back valid_in.
    for (int v = 0; v < 17; v++) begin
      pulse(vecs[v].lo_code);
      idle(vecs[v].gap - 1);
      pulse(vecs[v].hi_code);
      @(negedge clk);
      err_exp += vecs[v].exp_errs;
      chk($sformatf("vec%0d_level", v), 32'(fifo_level), 32'd1);
      chk($sformatf("vec%0d_errcnt", v), 32'(err_count), 32'(err_exp));
      pop_check($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_corr);
      chk($sformatf("vec%0d_empty", v), 32'(fifo_level), 32'd0);
    end

    // Fill the FIFO, then push and pop at the same edge while full.
    for (int p = 0; p < 4; p++) begin
      pulse(7'h2D);
      pulse(7'h52);
    end
    @(negedge clk);
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd0);
    pulse(7'h2D);
    pulse(7'h52);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pushpop_level", 32'(fifo_level), 32'd4);
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    pulse(7'h2D);
    pulse(7'h52);
    @(negedge clk);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int p = 0; p < 4; p++) pop_check($sformatf("drain%0d", p), 8'hA5, 1'b0);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Unpaired low nibble is discarded after the timeout.
    pulse(7'h2D);
    idle(TIMEOUT + 5);
    chk("tmo_nobyte", 32'(fifo_level), 32'd0);
    pulse(7'h52);
    pulse(7'h2D);
    @(negedge clk);
    pop_check("tmo_after", 8'h5A, 1'b0);

    // Second codeword landing on the expiry edge still completes the pair.
    pulse(7'h2D);
    idle(TIMEOUT - 1);
    pulse(7'h52);
    @(negedge clk);
    pop_check("tmo_edge_pair", 8'hA5, 1'b0);

    // One cycle later the low nibble has already expired.
    pulse(7'h2D);
    idle(TIMEOUT);
    pulse(7'h52);
    @(negedge clk);
    chk("tmo_late_nobyte", 32'(fifo_level), 32'd0);
    pulse(7'h2D);
    @(negedge clk);
    pop_check("tmo_late_pair", 8'h5A, 1'b0);

    // With ena low, pulses are lost and no pop happens.
    pulse(7'h2D);
    ena = 1'b0;
    pulse(7'h7F);
    idle(3);
    chk("ena_hold_level", 32'(fifo_level), 32'd0);
    ena = 1'b1;
    pulse(7'h52);
    @(negedge clk);
    chk("ena_level", 32'(fifo_level), 32'd1);
    ena = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("ena_nopop", 32'(fifo_level), 32'd1);
    out_ready = 1'b0;
    ena = 1'b1;
    pop_check("ena_pair", 8'hA5, 1'b0);

    // Error counter saturation.
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      pulse(7'h3D);
      if (err_exp < 255) err_exp++;
    end
    idle(4);
    out_ready = 1'b0;
    chk("sat_errcnt", 32'(err_count), 32'(err_exp));
    chk("sat_errcnt_max", 32'(err_count), 32'd255);
    chk("sat_drained", 32'(fifo_level), 32'd0);

    // Async reset mid-pair with two bytes queued.
    pulse(7'h2D);
    pulse(7'h52);
    pulse(7'h2D);
    pulse(7'h52);
    pulse(7'h2D);
    @(negedge clk);
    chk("pre_rst_level", 32'(fifo_level), 32'd2);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(7'h2D);
    pulse(7'h52);
    @(negedge clk);
    chk("post_rst_level", 32'(fifo_level), 32'd1);
    pop_check("post_rst", 8'hA5, 1'b0);
    chk("post_rst_empty", 32'(fifo_level), 32'd0);
    chk("post_rst_err", 32'(err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_byte_assembler.md
# hamming_byte_assembler

Downstream stage of the UART receiver. Accepts each validated 7-bit Hamming(7,4) codeword, corrects any single-bit error, and pairs successive nibbles into bytes (low nibble first). Completed bytes go into a small FIFO that the core logic drains through a valid/ready handshake. Error statistics are kept for debug visibility.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255: idle cycles after which an unpaired low nibble is discarded; 1..65535.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: when low, all registers hold (pipeline, FIFO, counters, timeout).
- `data_in` in 7: codeword; `data_in[0]` is the first bit received.
- `valid_in` in 1: one-cycle pulse; `data_in` is valid. Ignored when `ena`=0.
- `out_data` out 8: FIFO head byte, `{hi_nibble, lo_nibble}`.
- `out_corrected` out 1: FIFO head flag; either nibble of the byte needed correction.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head when `out_valid`=1.
- `err_count` out 8: count of corrected codewords, saturating at 255.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `fifo_level` out clog2(DEPTH)+1: current occupancy.

## Operation
- Codeword positions 1..7 map to `c[0]`..`c[6]`:
  - Parity bits: p1=`c[0]`, p2=`c[1]`, p4=`c[3]`.
  - Data bits: d1=`c[2]`, d2=`c[4]`, d3=`c[5]`, d4=`c[6]`.
- Syndrome bits:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - s = {s4,s2,s1}
- If s≠0, invert `c[s-1]`. The nibble is {d4,d3,d2,d1} taken after correction.
- Double-bit errors are not detected. They are miscorrected, and this is accepted behaviour.
- Stage 1: on `valid_in`&`ena`, register `data_in` into `code_q` and set `code_v`. `code_v` clears the next cycle unless another valid arrives.
- Stage 2 (when `code_v`):
  - Decode the codeword. If s≠0, increment `err_count` (saturating).
  - With `half`=0: store the nibble and its error flag as the low half, then set `half`=1.
  - With `half`=1: write {nibble, lo} and flag (own OR low) to the FIFO, then clear `half`.
- Pairing timeout:
  - `tmo_cnt` resets to 0 whenever `half`=0 or `code_v`=1. Otherwise it increments while `half`=1.
  - When `tmo_cnt` reaches TIMEOUT-1, clear `half` and discard the low nibble. `err_count` is not affected.
  - If timeout expiry and `code_v` coincide, `code_v` wins: the nibble completes the pair.
- FIFO write rules:
  - A write is accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set to 1. Only reset clears it.
- FIFO pop: occurs on `out_valid`&`out_ready`&`ena`. A simultaneous push and pop leaves the level unchanged.
- Pointers wrap modulo DEPTH.
- `out_data` and `out_corrected` are don't-care when `out_valid`=0.
- Reset (asynchronous, any time, including mid-pair or with a full FIFO):
  - Outputs go to `out_data`=0, `out_corrected`=0, `out_valid`=0, `err_count`=0, `overflow`=0, `fifo_level`=0.
  - Internal state goes to `half`=0, `code_v`=0, `tmo_cnt`=0, and both pointers=0.

## Timing
- A `valid_in` sampled at edge N leaves `code_v`=1 after N. Stage 2 acts at edge N+1.
- The `err_count` update is visible after edge N+1.
- For a second nibble, the byte is in the FIFO after N+1, and `out_valid` rises in cycle N+1 (registered level).
- Back-to-back `valid_in` on every cycle is supported at full rate.
- Pop at edge M: the head advances and `fifo_level` decrements after M.
- From a full FIFO, a pop and a push at the same edge both succeed with no overflow.
- When `ena`=0 for k cycles, all timing stretches by k. A `valid_in` pulse during `ena`=0 is lost.

## Test plan
- Send 0x2D then 0x52 (72 cycles apart), `out_ready`=1 → `out_data`=0xA5, `out_corrected`=0, `err_count`=0.
- Send 0x3D (bit 4 flipped, s=5) then 0x52 → `out_data`=0xA5, `out_corrected`=1, `err_count`=1. Sweep all 7 single-bit flips of both codewords; every case yields 0xA5.
- `out_ready`=0, send 5 pairs of 0x2D/0x52 with DEPTH=4 → `fifo_level`=4, `overflow`=1. Then drain → exactly 4 × 0xA5.
- Send 0x2D, idle TIMEOUT cycles, then 0x52, 0x2D → no byte is produced after the timeout, and the next pair yields 0x5A.
- Send 300 corrupted codewords → `err_count` saturates at 255.
- Assert `rst_n`=0 mid-pair with the FIFO holding 2 bytes → all outputs are 0 immediately. Then 0x2D/0x52 → single 0xA5.
